countdown_timer: RTL and testbench

Loadable down-counter timer, the counterpart of the team's 4-bit up-counter: it accepts a start value over a valid/ready load handshake and decrements it to zero under an enable. On reaching zero it raises a one-cycle terminal-count pulse. It sits beside the up-counter in the counter datapath, where it generates programmed delays and expiry events.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the loadable down-counter timer.
package countdown_pkg;

  localparam int COUNTDOWN_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cd_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// Optional periodic reload: define COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cnt_ena,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) reload_q <= '0;
    else       reload_q <= reload_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (abort) begin
      // In IDLE this is a no-op and swallows any same-edge load.
      if (state_q != IDLE) begin
        state_d = IDLE;
        count_d = '0;
      end
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            count_d = load_value;
            state_d = (load_value == '0) ? DONE : RUN;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_d = load_value;
`endif
          end
        end
        RUN: begin
          if (cnt_ena) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign tc         = (state_q == DONE);
  assign count      = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         cnt_ena;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .cnt_ena    (cnt_ena),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    cnt_ena = 1'b0;
    abort = 1'b0;
    #3;
    checks++;
    if ({count, tc, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_init: count=%0d tc=%b busy=%b rdy=%b, want 0 0 0 1",
               count, tc, busy, load_ready);
    end
    step();
    reset = 1'b0;
    step();
    cnt_ena = 1'b1;
    do_load(4'd9);
    step(); step(); step();
    checks++;
    if (count !== 4'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun: count=%0d busy=%b, want 6 1", count, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({count, tc, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_midrun: count=%0d tc=%b busy=%b rdy=%b, want 0 0 0 1",
               count, tc, busy, load_ready);
    end
    #1 reset = 1'b0;
    step();
    checks++;
    if (count !== 4'd0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: count=%0d rdy=%b, want 0 1", count, load_ready);
    end
  endtask

  task automatic test_basic();
    cnt_ena = 1'b1;
    do_load(4'd5);
    checks++;
    if (count !== 4'd5 || busy !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: count=%0d busy=%b rdy=%b, want 5 1 0",
               count, busy, load_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (count !== W'(5 - k) || tc !== 1'b0) begin
        errors++;
        $display("FAIL basic_dec%0d: count=%0d tc=%b, want %0d 0",
                 k, count, tc, 5 - k);
      end
    end
    step();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_tc: count=%0d tc=%b busy=%b, want 0 1 0",
               count, tc, busy);
    end
    step();
    checks++;
    if (tc !== 1'b0 || load_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL basic_idle: tc=%b rdy=%b count=%0d, want 0 1 0",
               tc, load_ready, count);
    end
  endtask

  task automatic test_stall();
    logic [4:0] ena_pat;
    logic [3:0] exp_cnt [5];
    ena_pat = 5'b11001;
    exp_cnt = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    cnt_ena = 1'b0;
    do_load(4'd3);
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_load: count=%0d busy=%b, want 3 1", count, busy);
    end
    for (int k = 0; k < 5; k++) begin
      cnt_ena = ena_pat[k];
      step();
      checks++;
      if (count !== exp_cnt[k] || tc !== (k == 4) || busy !== (k != 4)) begin
        errors++;
        $display("FAIL stall_e%0d: count=%0d tc=%b busy=%b, want %0d %b %b",
                 k, count, tc, busy, exp_cnt[k], k == 4, k != 4);
      end
    end
    cnt_ena = 1'b1;
    step();
  endtask

  task automatic test_zero_max();
    cnt_ena = 1'b1;
    do_load(4'd0);
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_tc: count=%0d tc=%b rdy=%b busy=%b, want 0 1 0 0",
               count, tc, load_ready, busy);
    end
    step();
    checks++;
    if (tc !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: tc=%b rdy=%b, want 0 1", tc, load_ready);
    end
    do_load(4'd15);
    for (int k = 0; k < 14; k++) step();
    checks++;
    if (count !== 4'd1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL max_pre: count=%0d tc=%b, want 1 0", count, tc);
    end
    step();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max_tc: count=%0d tc=%b, want 0 1", count, tc);
    end
    step();
    checks++;
    if (count !== 4'd0 || load_ready !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL max_nowrap: count=%0d rdy=%b tc=%b, want 0 1 0",
               count, load_ready, tc);
    end
  endtask

  task automatic test_abort();
    cnt_ena = 1'b1;
    do_load(4'd7);
    step(); step(); step();
    checks++;
    if (count !== 4'd4) begin
      errors++;
      $display("FAIL abort_pre: count=%0d, want 4", count);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({count, tc, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_run: count=%0d tc=%b busy=%b rdy=%b, want 0 0 0 1",
               count, tc, busy, load_ready);
    end
    step();
    checks++;
    if (tc !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_notc: tc=%b rdy=%b, want 0 1", tc, load_ready);
    end
    abort = 1'b1;
    do_load(4'd3);
    abort = 1'b0;
    checks++;
    if (count !== 4'd0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_drop: count=%0d rdy=%b busy=%b, want 0 1 0",
               count, load_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    cnt_ena = 1'b1;
    load_valid = 1'b1;
    load_value = 4'd2;
    step();
    checks++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load: count=%0d busy=%b, want 2 1", count, busy);
    end
    step();
    checks++;
    if (count !== 4'd1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_run: count=%0d rdy=%b, want 1 0", count, load_ready);
    end
    step();
    checks++;
    if (tc !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: tc=%b rdy=%b, want 1 0", tc, load_ready);
    end
    step();
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_idle: rdy=%b busy=%b count=%0d, want 1 0 0",
               load_ready, busy, count);
    end
    step();
    load_valid = 1'b0;
    checks++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload: count=%0d busy=%b, want 2 1", count, busy);
    end
    step(); step(); step();
    checks++;
    if (load_ready !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: rdy=%b tc=%b, want 1 0", load_ready, tc);
    end
  endtask

  task automatic test_autoreload();
    cnt_ena = 1'b1;
    do_load(4'd2);
    for (int p = 0; p < 3; p++) begin
      step();
      step();
      checks++;
      if (tc !== 1'b1 || count !== 4'd0) begin
        errors++;
        $display("FAIL ar_tc%0d: tc=%b count=%0d, want 1 0", p, tc, count);
      end
      step();
      checks++;
      if (count !== 4'd2 || busy !== 1'b1 || tc !== 1'b0) begin
        errors++;
        $display("FAIL ar_reload%0d: count=%0d busy=%b tc=%b, want 2 1 0",
                 p, count, busy, tc);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL ar_abort: rdy=%b count=%0d, want 1 0", load_ready, count);
    end
    do_load(4'd0);
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL ar_zero_tc: tc=%b, want 1", tc);
    end
    step();
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL ar_zero_idle: rdy=%b busy=%b tc=%b, want 1 0 0",
               load_ready, busy, tc);
    end
  endtask

  initial begin
    test_reset();
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    test_autoreload();
`else
    test_basic();
    test_stall();
    test_zero_max();
    test_abort();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
